engine_dispatch_ctrl: RTL and testbench

Controller that sits between the SPI slave word interface and the two compute engines (GCD and Sobel) inside `tt_um_sobel_gcd_unal`. It classifies each received 16-bit word, builds GCD operand pairs or 9-word Sobel windows, and starts the selected engine. It then waits for completion, loads the result into the SPI transmit register and raises the done flag that drives `uio_out[5]`. It also enforces the external enables (`gcd_en`, `sobel_allowed`, `sobel_en`), flags protocol errors and aborts hung engines with a watchdog.

---
 rtl/sobel_gcd_pkg.sv | 18 +
 rtl/engine_dispatch_ctrl_if.sv | 38 +++
 rtl/sync_rise.sv | 34 +++
 rtl/engine_dispatch_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_engine_dispatch_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_gcd_pkg.sv
// Shared types and constants for the SPI-to-engine dispatch controller.
package sobel_gcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GCD_B,
        ST_GCD_ARM,
        ST_GCD_RUN,
        ST_SOB_FILL,
        ST_SOB_RUN,
        ST_DONE
    } dispatch_state_t;

    // rx_data[15] selects the word type: 0 = GCD operand, 1 = Sobel pixel.
    localparam int WORD_TYPE_BIT        = 15;
    localparam int DEFAULT_WINDOW_WORDS = 9;

endpackage

// File: rtl/engine_dispatch_ctrl_if.sv
// Bundle of SPI word, engine and status signals around the dispatch controller.
// master = the controller, slave = SPI slave, engines and pins around it.
interface engine_dispatch_ctrl_if;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        gcd_en;
    logic        sobel_allowed;
    logic        sobel_en;
    logic [14:0] gcd_a;
    logic [14:0] gcd_b;
    logic        gcd_start;
    logic        gcd_done;
    logic [14:0] gcd_result;
    logic [14:0] sob_pix;
    logic        sob_pix_valid;
    logic        sob_start;
    logic        sob_done;
    logic [15:0] sob_result;
    logic [15:0] tx_data;
    logic        tx_load;
    logic        done_o;
    logic        busy_o;
    logic        err_o;

    modport master (
        input  rx_data, rx_valid, gcd_en, sobel_allowed, sobel_en,
               gcd_done, gcd_result, sob_done, sob_result,
        output gcd_a, gcd_b, gcd_start, sob_pix, sob_pix_valid, sob_start,
               tx_data, tx_load, done_o, busy_o, err_o
    );

    modport slave (
        output rx_data, rx_valid, gcd_en, sobel_allowed, sobel_en,
               gcd_done, gcd_result, sob_done, sob_result,
        input  gcd_a, gcd_b, gcd_start, sob_pix, sob_pix_valid, sob_start,
               tx_data, tx_load, done_o, busy_o, err_o
    );
endinterface

// File: rtl/sync_rise.sv
// N-stage synchronizer for an asynchronous pin plus a rising-edge detector
// on the synchronized level.
module sync_rise #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    // Shift the pin through the chain and remember the last synced level.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    // Synchronizer and edge-history flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;
endmodule

// File: rtl/engine_dispatch_ctrl.sv
// Classifies incoming SPI words, builds GCD operand pairs or Sobel windows,
// starts the engine, returns its result to the SPI transmit register and
// guards against protocol errors and hung engines.
module engine_dispatch_ctrl
    import sobel_gcd_pkg::*;
#(
    parameter int WINDOW_WORDS   = DEFAULT_WINDOW_WORDS,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int SYNC_STAGES    = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    engine_dispatch_ctrl_if.master bus
);
    localparam int              CW       = $clog2(WINDOW_WORDS + 1);
    localparam logic [CW-1:0]   WIN_FULL = CW'(WINDOW_WORDS);
    localparam logic [15:0]     WD_LAST  = 16'(TIMEOUT_CYCLES - 1);

    logic gcd_en_lvl, gcd_en_rise_unused;
    logic allowed_lvl, allowed_rise_unused;
    logic sob_en_lvl_unused, sob_en_rise;

    sync_rise #(.STAGES(SYNC_STAGES)) u_sync_gcd_en (
        .clk(clk), .rst_n(rst_n), .d(bus.gcd_en),
        .level(gcd_en_lvl), .rise(gcd_en_rise_unused)
    );
    sync_rise #(.STAGES(SYNC_STAGES)) u_sync_allowed (
        .clk(clk), .rst_n(rst_n), .d(bus.sobel_allowed),
        .level(allowed_lvl), .rise(allowed_rise_unused)
    );
    sync_rise #(.STAGES(SYNC_STAGES)) u_sync_sob_en (
        .clk(clk), .rst_n(rst_n), .d(bus.sobel_en),
        .level(sob_en_lvl_unused), .rise(sob_en_rise)
    );

    dispatch_state_t state_q, state_d;
    logic [14:0]     gcd_a_q, gcd_a_d, gcd_b_q, gcd_b_d;
    logic [14:0]     pend_q, pend_d;
    logic            pend_vld_q, pend_vld_d;
    logic [CW-1:0]   win_cnt_q, win_cnt_d;
    logic [14:0]     sob_pix_q, sob_pix_d;
    logic            sob_pix_valid_q, sob_pix_valid_d;
    logic            sob_start_q, sob_start_d;
    logic            gcd_start_q, gcd_start_d;
    logic [15:0]     tx_data_q, tx_data_d;
    logic            tx_load_q, tx_load_d;
    logic            err_q, err_d;
    logic [15:0]     wd_cnt_q, wd_cnt_d;

    logic            is_sob;
    logic [14:0]     payload;
    logic            push;

    assign is_sob  = bus.rx_data[WORD_TYPE_BIT];
    assign payload = bus.rx_data[WORD_TYPE_BIT-1:0];
    assign push    = sob_en_rise && pend_vld_q;

    // Next-state and registered-output logic for the dispatch FSM.
    always_comb begin
        // NOTE: every _d gets a default first, so no path through the case leaves one unassigned (no latch).
        state_d         = state_q;
        gcd_a_d         = gcd_a_q;
        gcd_b_d         = gcd_b_q;
        pend_d          = pend_q;
        pend_vld_d      = pend_vld_q;
        win_cnt_d       = win_cnt_q;
        sob_pix_d       = sob_pix_q;
        sob_pix_valid_d = 1'b0;
        sob_start_d     = 1'b0;
        gcd_start_d     = 1'b0;
        tx_data_d       = tx_data_q;
        tx_load_d       = 1'b0;
        err_d           = err_q;
        wd_cnt_d        = wd_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    if (!is_sob) begin
                        gcd_a_d = payload;
                        state_d = ST_GCD_B;
                    end else if (allowed_lvl) begin
                        pend_d     = payload;
                        pend_vld_d = 1'b1;
                        win_cnt_d  = '0;
                        state_d    = ST_SOB_FILL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_GCD_B: begin
                if (bus.rx_valid) begin
                    if (!is_sob) begin
                        gcd_b_d = payload;
                        state_d = ST_GCD_ARM;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GCD_ARM: begin
                if (bus.rx_valid) err_d = 1'b1;
                if (gcd_en_lvl) begin
                    gcd_start_d = 1'b1;
                    wd_cnt_d    = '0;
                    state_d     = ST_GCD_RUN;
                end
            end
            ST_GCD_RUN: begin
                if (bus.rx_valid) err_d = 1'b1;
                // A completion in the expiry cycle still delivers its result.
                if (bus.gcd_done) begin
                    tx_data_d = {1'b0, bus.gcd_result};
                    tx_load_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (wd_cnt_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
            end
            ST_SOB_FILL: begin
                if (win_cnt_q == WIN_FULL) begin
                    // Window complete: start the engine one cycle after the last push.
                    if (bus.rx_valid) err_d = 1'b1;
                    sob_start_d = 1'b1;
                    wd_cnt_d    = '0;
                    state_d     = ST_SOB_RUN;
                end else begin
                    if (push) begin
                        sob_pix_d       = pend_q;
                        sob_pix_valid_d = 1'b1;
                        pend_vld_d      = 1'b0;
                        win_cnt_d       = win_cnt_q + CW'(1);
                    end
                    if (bus.rx_valid) begin
                        if (!is_sob) begin
                            err_d      = 1'b1;
                            pend_vld_d = 1'b0;
                            win_cnt_d  = '0;
                            state_d    = ST_IDLE;
                        end else begin
                            // Overwriting an unpushed word is an error; a same-cycle push is not.
                            if (pend_vld_q && !push) err_d = 1'b1;
                            pend_d     = payload;
                            pend_vld_d = 1'b1;
                        end
                    end
                end
            end
            ST_SOB_RUN: begin
                if (bus.rx_valid) err_d = 1'b1;
                if (bus.sob_done) begin
                    tx_data_d = bus.sob_result;
                    tx_load_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (wd_cnt_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                // The readback transfer's word carries no command.
                if (bus.rx_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            gcd_a_q         <= '0;
            gcd_b_q         <= '0;
            pend_q          <= '0;
            pend_vld_q      <= 1'b0;
            win_cnt_q       <= '0;
            sob_pix_q       <= '0;
            sob_pix_valid_q <= 1'b0;
            sob_start_q     <= 1'b0;
            gcd_start_q     <= 1'b0;
            tx_data_q       <= '0;
            tx_load_q       <= 1'b0;
            err_q           <= 1'b0;
            wd_cnt_q        <= '0;
        end else begin
            // NOTE: non-blocking so every flop updates from the same pre-edge values.
            state_q         <= state_d;
            gcd_a_q         <= gcd_a_d;
            gcd_b_q         <= gcd_b_d;
            pend_q          <= pend_d;
            pend_vld_q      <= pend_vld_d;
            win_cnt_q       <= win_cnt_d;
            sob_pix_q       <= sob_pix_d;
            sob_pix_valid_q <= sob_pix_valid_d;
            sob_start_q     <= sob_start_d;
            gcd_start_q     <= gcd_start_d;
            tx_data_q       <= tx_data_d;
            tx_load_q       <= tx_load_d;
            err_q           <= err_d;
            wd_cnt_q        <= wd_cnt_d;
        end
    end

    assign bus.gcd_a         = gcd_a_q;
    assign bus.gcd_b         = gcd_b_q;
    assign bus.gcd_start     = gcd_start_q;
    assign bus.sob_pix       = sob_pix_q;
    assign bus.sob_pix_valid = sob_pix_valid_q;
    assign bus.sob_start     = sob_start_q;
    assign bus.tx_data       = tx_data_q;
    assign bus.tx_load       = tx_load_q;
    assign bus.err_o         = err_q;
    assign bus.done_o        = (state_q == ST_DONE);
    assign bus.busy_o        = (state_q != ST_IDLE) && (state_q != ST_DONE);
endmodule

// File: tb/tb_engine_dispatch_ctrl.sv
// Scoreboard bench for engine_dispatch_ctrl: expected pixels and results are
// queued when stimulus is driven and checked when the DUT emits them.
module tb_engine_dispatch_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    engine_dispatch_ctrl_if bus();

    engine_dispatch_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_err = 0;
    int n_chk = 0;
    logic [15:0] exp_tx_q[$];
    logic [14:0] exp_pix_q[$];
    int pix_cnt = 0, tx_cnt = 0, sstart_cnt = 0, gstart_cnt = 0;
    logic        gcd_stub_on = 1'b1;
    logic [14:0] gcd_stub_val = '0;
    logic [15:0] sob_stub_val = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every pixel push and result load.
    initial forever begin
        @(negedge clk);
        if (bus.sob_pix_valid) begin
            pix_cnt++;
            if (exp_pix_q.size() == 0) check("pix_unexpected_q_depth", exp_pix_q.size(), 1);
            else check("sob_pix", bus.sob_pix, exp_pix_q.pop_front());
        end
        if (bus.tx_load) begin
            tx_cnt++;
            check("done_with_tx_load", bus.done_o, 1);
            if (exp_tx_q.size() == 0) check("tx_unexpected_q_depth", exp_tx_q.size(), 1);
            else check("tx_data", bus.tx_data, exp_tx_q.pop_front());
        end
        if (bus.sob_start) sstart_cnt++;
        if (bus.gcd_start) gstart_cnt++;
    end

    // GCD engine stub.
    initial begin
        bus.gcd_done = 1'b0;
        bus.gcd_result = '0;
        forever begin
            @(negedge clk);
            if (bus.gcd_start && gcd_stub_on) begin
                repeat (3) @(negedge clk);
                bus.gcd_result = gcd_stub_val;
                bus.gcd_done = 1'b1;
                @(negedge clk);
                bus.gcd_done = 1'b0;
            end
        end
    end

    // Sobel engine stub.
    initial begin
        bus.sob_done = 1'b0;
        bus.sob_result = '0;
        forever begin
            @(negedge clk);
            if (bus.sob_start) begin
                repeat (4) @(negedge clk);
                bus.sob_result = sob_stub_val;
                bus.sob_done = 1'b1;
                @(negedge clk);
                bus.sob_done = 1'b0;
            end
        end
    end

    task automatic send_word(input logic [15:0] w);
        @(negedge clk);
        bus.rx_data = w;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    // 100 ns high pulse on the sobel_en pin, then settle time.
    task automatic pulse_sobel_en();
        @(negedge clk);
        bus.sobel_en = 1'b1;
        repeat (10) @(negedge clk);
        bus.sobel_en = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.rx_valid = 1'b0;
        bus.sobel_en = 1'b0;
        repeat (3) @(negedge clk);
        exp_tx_q.delete();
        exp_pix_q.delete();
        pix_cnt = 0; tx_cnt = 0; sstart_cnt = 0; gstart_cnt = 0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!bus.done_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.done_o, 1);
    endtask

    initial begin
        logic [15:0] w;
        int n, cyc;
        bus.rx_data = '0; bus.rx_valid = 1'b0;
        bus.gcd_en = 1'b0; bus.sobel_allowed = 1'b0; bus.sobel_en = 1'b0;

        // Reset state
        do_reset();
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_done", bus.done_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_err", bus.err_o, 0);
        check("rst_gcd_a", bus.gcd_a, 0);

        // GCD: 0x2004, 0x0008 -> 4
        gcd_stub_val = 15'd4;
        exp_tx_q.push_back(16'h0004);
        send_word(16'h2004);
        check("gcd_a", bus.gcd_a, 15'h2004);
        check("gcd_busy_b", bus.busy_o, 1);
        send_word(16'h0008);
        check("gcd_b", bus.gcd_b, 15'h0008);
        repeat (3) @(negedge clk);
        check("gcd_no_start_wo_en", gstart_cnt, 0);
        bus.gcd_en = 1'b1;
        wait_done("gcd_done_o", 50);
        check("gcd_start_cnt", gstart_cnt, 1);
        check("gcd_busy_done", bus.busy_o, 0);
        bus.gcd_en = 1'b0;
        send_word(16'h0000);
        check("gcd_readback_done", bus.done_o, 0);
        check("gcd_readback_idle", bus.busy_o, 0);
        check("gcd_err", bus.err_o, 0);

        // Sobel window of nine words
        bus.sobel_allowed = 1'b1;
        repeat (4) @(negedge clk);
        sob_stub_val = 16'h1234;
        exp_tx_q.push_back(16'h1234);
        for (int i = 0; i < 9; i++) begin
            w = 16'(16'hAAA0 + i);
            exp_pix_q.push_back(w[14:0]);
            send_word(w);
            pulse_sobel_en();
        end
        wait_done("sob_done_o", 50);
        check("sob_pix_cnt", pix_cnt, 9);
        check("sob_start_cnt", sstart_cnt, 1);
        check("sob_err", bus.err_o, 0);
        send_word(16'h0000);
        check("sob_readback_done", bus.done_o, 0);

        // Sobel word while not allowed
        do_reset();
        bus.sobel_allowed = 1'b0;
        repeat (4) @(negedge clk);
        send_word(16'h8123);
        bus.sobel_en = 1'b1;
        repeat (6) @(negedge clk);
        bus.sobel_en = 1'b0;
        check("na_err", bus.err_o, 1);
        check("na_busy", bus.busy_o, 0);
        check("na_pix_cnt", pix_cnt, 0);

        // Reset mid-window after four pushes, then a fresh full window
        do_reset();
        bus.sobel_allowed = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            w = 16'(16'h8100 + i);
            exp_pix_q.push_back(w[14:0]);
            send_word(w);
            pulse_sobel_en();
        end
        check("mid_pix_cnt", pix_cnt, 4);
        send_word(16'h81FF);
        do_reset();
        check("mid_rst_busy", bus.busy_o, 0);
        check("mid_rst_err", bus.err_o, 0);
        sob_stub_val = 16'h0BEE;
        exp_tx_q.push_back(16'h0BEE);
        for (int i = 0; i < 9; i++) begin
            w = 16'(16'h8200 + 3 * i);
            exp_pix_q.push_back(w[14:0]);
            send_word(w);
            pulse_sobel_en();
            if (i == 7) begin
                check("mid_8_pushes", pix_cnt, 8);
                check("mid_no_early_start", sstart_cnt, 0);
            end
        end
        wait_done("mid_done_o", 50);
        check("mid_start_cnt", sstart_cnt, 1);
        send_word(16'h0000);

        // Second Sobel word before any edge overwrites the pending word
        do_reset();
        bus.sobel_allowed = 1'b1;
        repeat (4) @(negedge clk);
        send_word(16'h8111);
        check("ovw_no_err_first", bus.err_o, 0);
        send_word(16'h8222);
        check("ovw_err", bus.err_o, 1);
        exp_pix_q.push_back(15'h0222);
        pulse_sobel_en();
        check("ovw_pix_cnt", pix_cnt, 1);
        pulse_sobel_en();
        check("ovw_empty_edge_ignored", pix_cnt, 1);

        // Watchdog on a GCD engine that never answers
        do_reset();
        gcd_stub_on = 1'b0;
        bus.gcd_en = 1'b1;
        send_word(16'h0015);
        send_word(16'h0023);
        n = 0;
        while (!bus.gcd_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wd_start_seen", bus.gcd_start, 1);
        cyc = 0;
        while (bus.busy_o && cyc < 70000) begin
            @(negedge clk);
            cyc++;
        end
        check("wd_cycles", cyc, 65535);
        check("wd_err", bus.err_o, 1);
        check("wd_no_tx_load", tx_cnt, 0);
        check("wd_done", bus.done_o, 0);
        bus.gcd_en = 1'b0;

        check("pix_q_drained", exp_pix_q.size(), 0);
        check("tx_q_drained", exp_tx_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
